// File: rtl/mem_port_arbiter_m1.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : mem_port_arbiter_m1
// Brief   : Two-requester (fetch / data) arbiter for the single-port M1T memory,
//           data-priority with a starvation bound guaranteeing fetch progress.
// Revision: 1.0  initial release
// ============================================================================
module mem_port_arbiter_m1 #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              async_rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LATENCY - 1);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;
    typedef enum logic [0:0] {OWN_DATA = 1'b0, OWN_FETCH = 1'b1} owner_t;

    state_t             state;
    owner_t             owner;
    logic [LAT_W-1:0]   lat_cnt;
    logic [STV_W-1:0]   starve_cnt;

    logic any_req;
    logic pick_fetch;
    logic grant;
    logic done;

    assign any_req    = if_req | d_req;
    assign pick_fetch = if_req & (~d_req | (starve_cnt == STV_MAX));

    // Outputs are combinational, so they are gated with reset to stay low while it is held.
    assign grant = async_rst & (state == S_IDLE) & any_req;
    assign done  = async_rst & (state == S_WAIT) & (lat_cnt == '0);

    assign if_gnt    = grant & pick_fetch;
    assign d_gnt     = grant & ~pick_fetch;
    assign mem_en    = grant;
    assign mem_we    = d_gnt & d_we;
    assign mem_addr  = if_gnt ? if_addr : (d_gnt ? d_addr : '0);
    assign mem_wdata = d_gnt ? d_wdata : '0;

    assign if_rvalid = done & (owner == OWN_FETCH);
    assign d_rvalid  = done & (owner == OWN_DATA);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid ? mem_rdata : '0;

    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            state      <= S_IDLE;
            owner      <= OWN_DATA;
            lat_cnt    <= '0;
            starve_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        owner   <= pick_fetch ? OWN_FETCH : OWN_DATA;
                        lat_cnt <= LAT_INIT;
                        state   <= S_WAIT;
                    end
                    // A data win with fetch waiting is the only case that advances the count.
                    if (!if_req || pick_fetch) begin
                        starve_cnt <= '0;
                    end else if (d_req && (starve_cnt != STV_MAX)) begin
                        starve_cnt <= starve_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (lat_cnt != '0) begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
